// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter.
// One bit per clock; result register holds between conversions.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [4*DIGITS-1:0] bcd_out
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [31:0] MAXV = 32'(10**DIGITS - 1);
  localparam logic [DW-1:0] NINES = {DIGITS{4'h9}};
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [BIN_W-1:0]  shreg;
  logic [DW-1:0]     scratch;
  logic [DW-1:0]     adj;
  logic [CW-1:0]     bit_cnt;
  logic              ovf_n;

  assign busy = (state != IDLE);

  // Digit correction happens before every shift, never after the last.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      ovf_n   <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            bit_cnt <= '0;
            ovf_n   <= 32'(bin_in) > MAXV;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          bcd_out <= ovf_n ? NINES : scratch;
          ovf     <= ovf_n;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and swept checks for bin2bcd_seq.
// Expected BCD comes from a decimal-division reference.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd_out;

  int n_chk;
  int n_pass;

  bin2bcd_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [15:0] bcd_ref(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the next edge.
  task automatic convert(input int v);
    int   lat;
    logic seen;
    lat    = 0;
    seen   = 1'b0;
    bin_in = 14'(v);
    start  = 1'b1;
    cyc();
    start = 1'b0;
    chk($sformatf("busy_%0d", v), 32'(busy), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        seen = 1'b1;
        lat  = c - 1;
        break;
      end
      cyc();
    end
    chk($sformatf("seen_%0d", v), 32'(seen), 32'd1);
    chk($sformatf("lat_%0d", v), 32'(lat), 32'd15);
    chk($sformatf("bcd_%0d", v), 32'(bcd_out),
        32'(bcd_ref(v)));
    chk($sformatf("ovf_%0d", v), 32'(ovf),
        32'(v > 9999));
  endtask

  initial begin
    int   ndone;
    int   first;
    logic hold_ok;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    rst_n = 1'b1;
    cyc();

    convert(1234);
    chk("hand_1234", 32'(bcd_out), 32'h1234);
    convert(0);
    chk("hand_0", 32'(bcd_out), 32'h0000);
    convert(9999);
    chk("hand_9999", 32'(bcd_out), 32'h9999);
    convert(10000);
    chk("ovf_10000", 32'(ovf), 32'd1);
    convert(16383);
    chk("hand_16383", 32'(bcd_out), 32'h9999);
    convert(42);
    chk("hand_42", 32'(bcd_out), 32'h0042);
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Re-pulse start during SHIFT and during DONE.
    ndone   = 0;
    first   = 0;
    hold_ok = 1'b1;
    bin_in  = 14'd777;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end else if (ndone == 0 && bcd_out !== 16'h0042) begin
        hold_ok = 1'b0;
      end
      if (c == 2 || c == 15) begin
        start  = 1'b1;
        bin_in = 14'd5;
      end else begin
        start = 1'b0;
      end
      cyc();
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_when", 32'(first), 32'd16);
    chk("ign_bcd", 32'(bcd_out), 32'h0777);
    chk("ign_hold", 32'(hold_ok), 32'd1);

    // Reset in the middle of a conversion.
    bin_in = 14'd4321;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    rst_n = 1'b0;
    cyc();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_bcd", 32'(bcd_out), 32'd0);
    rst_n = 1'b1;
    convert(4321);
    chk("hand_4321", 32'(bcd_out), 32'h4321);

    // Back-to-back sweep.
    for (int v = 0; v < 1024; v++) convert(v);
    for (int v = 1024; v < 16384; v += 97) convert(v);
    convert(16383);
    cyc();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
